// File: rtl/fir_cmd_sequencer.sv
// Command sequencer for the FIR estimator datapath: decodes opcodes into registered control strobes.
// Optional build macro FIR_SEQ_ILLEGAL_TRAP_EN makes illegal commands sticky and blocks the command port until rst.
module fir_cmd_sequencer #(
   parameter int N_W   = 8,
   parameter int K_W   = 6,
   parameter int ARG_W = 16,
   parameter int N_RST = 8,
   parameter int K_RST = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [ARG_W-1:0] cmd_arg,
   output logic             shift_h_en,
   output logic [4:0]       shift_h_addr,
   output logic             shift_s_en,
   output logic             calc_start,
   output logic [N_W-1:0]   calc_tap,
   output logic             calc_done,
   output logic             busy,
   output logic [N_W-1:0]   n_cfg,
   output logic [K_W-1:0]   k_cfg,
   output logic             err_illegal
);

   typedef enum logic [1:0] {IDLE, SHIFT_BURST, CALCULATE} state_t;
   typedef enum logic [2:0] {
      OP_SHIFT_H   = 3'b000,
      OP_SHIFT_S   = 3'b001,
      OP_CALC      = 3'b010,
      OP_NOP       = 3'b011,
      OP_NUM_SHIFT = 3'b100,
      OP_N_CHANGE  = 3'b101,
      OP_K_CHANGE  = 3'b110,
      OP_RSVD      = 3'b111
   } op_t;

   state_t           state_q, state_d;
   logic [ARG_W-1:0] burst_cnt_q, burst_cnt_d;
   logic             shift_h_en_d, shift_s_en_d, calc_start_d, calc_done_d, err_d;
   logic [4:0]       shift_h_addr_d;
   logic [N_W-1:0]   calc_tap_d, n_cfg_d;
   logic [K_W-1:0]   k_cfg_d;
   logic             illegal;
   logic             trap;
   logic             n_over, k_over;

`ifdef FIR_SEQ_ILLEGAL_TRAP_EN
   assign trap = err_illegal;
`else
   assign trap = 1'b0;
`endif

   assign cmd_ready = (state_q == IDLE) && !trap;
   assign busy      = (state_q != IDLE);
   assign n_over    = (cmd_arg >> N_W) != '0;
   assign k_over    = (cmd_arg >> K_W) != '0;

   // NOTE: every signal gets its default before the case so no path can infer a latch.
   always_comb begin
      state_d        = state_q;
      burst_cnt_d    = burst_cnt_q;
      shift_h_en_d   = 1'b0;
      shift_s_en_d   = 1'b0;
      calc_start_d   = 1'b0;
      calc_done_d    = 1'b0;
      shift_h_addr_d = shift_h_addr;
      calc_tap_d     = calc_tap;
      n_cfg_d        = n_cfg;
      k_cfg_d        = k_cfg;
      illegal        = 1'b0;

      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               case (op_t'(cmd_op))
                  OP_SHIFT_H: begin
                     shift_h_en_d   = 1'b1;
                     shift_h_addr_d = cmd_arg[4:0];
                  end
                  OP_SHIFT_S: shift_s_en_d = 1'b1;
                  OP_CALC: begin
                     state_d      = CALCULATE;
                     calc_tap_d   = '0;
                     calc_start_d = 1'b1;
                     calc_done_d  = (n_cfg == N_W'(1));
                  end
                  OP_NUM_SHIFT: begin
                     // Counter holds strobes still owed after the one issued next cycle.
                     if (cmd_arg != '0) begin
                        state_d      = SHIFT_BURST;
                        burst_cnt_d  = cmd_arg - ARG_W'(1);
                        shift_s_en_d = 1'b1;
                     end
                  end
                  OP_N_CHANGE: begin
                     if (cmd_arg == '0) illegal = 1'b1;
                     else if (n_over)   n_cfg_d = '1;
                     else               n_cfg_d = cmd_arg[N_W-1:0];
                  end
                  OP_K_CHANGE: begin
                     if (k_over) illegal = 1'b1;
                     else        k_cfg_d = cmd_arg[K_W-1:0];
                  end
                  OP_RSVD: illegal = 1'b1;
                  default: ;
               endcase
            end
         end
         SHIFT_BURST: begin
            if (burst_cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               burst_cnt_d  = burst_cnt_q - ARG_W'(1);
               shift_s_en_d = 1'b1;
            end
         end
         CALCULATE: begin
            if (calc_tap == n_cfg - N_W'(1)) begin
               state_d    = IDLE;
               calc_tap_d = '0;
            end else begin
               calc_tap_d  = calc_tap + N_W'(1);
               calc_done_d = (calc_tap + N_W'(1) == n_cfg - N_W'(1));
            end
         end
         default: state_d = IDLE;
      endcase

`ifdef FIR_SEQ_ILLEGAL_TRAP_EN
      err_d = err_illegal | illegal;
`else
      err_d = illegal;
`endif
   end

   // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         burst_cnt_q  <= '0;
         shift_h_en   <= 1'b0;
         shift_h_addr <= '0;
         shift_s_en   <= 1'b0;
         calc_start   <= 1'b0;
         calc_tap     <= '0;
         calc_done    <= 1'b0;
         n_cfg        <= N_W'(N_RST);
         k_cfg        <= K_W'(K_RST);
         err_illegal  <= 1'b0;
      end else begin
         state_q      <= state_d;
         burst_cnt_q  <= burst_cnt_d;
         shift_h_en   <= shift_h_en_d;
         shift_h_addr <= shift_h_addr_d;
         shift_s_en   <= shift_s_en_d;
         calc_start   <= calc_start_d;
         calc_tap     <= calc_tap_d;
         calc_done    <= calc_done_d;
         n_cfg        <= n_cfg_d;
         k_cfg        <= k_cfg_d;
         err_illegal  <= err_d;
      end
   end

endmodule

// File: tb/tb_fir_cmd_sequencer.sv
// Directed self-checking bench for fir_cmd_sequencer; inputs change and outputs are sampled on the falling edge.
module tb_fir_cmd_sequencer;

   localparam logic [2:0] SHIFT_H = 3'b000, SHIFT_S = 3'b001, CALC = 3'b010,
                          NUM_SHIFT = 3'b100, N_CHANGE = 3'b101, K_CHANGE = 3'b110,
                          RSVD = 3'b111;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_op;
   logic [15:0] cmd_arg;
   logic        shift_h_en;
   logic [4:0]  shift_h_addr;
   logic        shift_s_en;
   logic        calc_start;
   logic [7:0]  calc_tap;
   logic        calc_done;
   logic        busy;
   logic [7:0]  n_cfg;
   logic [5:0]  k_cfg;
   logic        err_illegal;

   int total  = 0;
   int passed = 0;

   fir_cmd_sequencer dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_arg(cmd_arg), .shift_h_en(shift_h_en),
      .shift_h_addr(shift_h_addr), .shift_s_en(shift_s_en), .calc_start(calc_start),
      .calc_tap(calc_tap), .calc_done(calc_done), .busy(busy), .n_cfg(n_cfg),
      .k_cfg(k_cfg), .err_illegal(err_illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Presents one command for one edge; returns at the falling edge of the cycle after acceptance.
   task automatic issue(input logic [2:0] op, input logic [15:0] arg);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_arg   = arg;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // After an illegal command: either the trap holds, or the flag was only a one-cycle pulse.
   task automatic recover(input string tag);
      tick();
`ifdef FIR_SEQ_ILLEGAL_TRAP_EN
      check({tag, " err sticky"}, err_illegal, 1);
      check({tag, " ready trapped"}, cmd_ready, 0);
      tick();
      check({tag, " still trapped"}, cmd_ready, 0);
      do_reset();
      check({tag, " ready after rst"}, cmd_ready, 1);
`else
      check({tag, " err pulse ends"}, err_illegal, 0);
      check({tag, " ready kept"}, cmd_ready, 1);
`endif
   endtask

   initial begin
      int strobes;
      cmd_valid = 1'b0;
      cmd_op    = 3'b011;
      cmd_arg   = '0;
      do_reset();

      // Reset state
      check("rst n_cfg", n_cfg, 8);
      check("rst k_cfg", k_cfg, 0);
      check("rst shift_h_en", shift_h_en, 0);
      check("rst shift_s_en", shift_s_en, 0);
      check("rst calc_start", calc_start, 0);
      check("rst calc_done", calc_done, 0);
      check("rst busy", busy, 0);
      check("rst err", err_illegal, 0);
      check("rst ready", cmd_ready, 1);

      // SHIFT_H: one-cycle strobe, address held afterwards
      issue(SHIFT_H, 16'h0013);
      check("shift_h en", shift_h_en, 1);
      check("shift_h addr", shift_h_addr, 5'b10011);
      tick();
      check("shift_h en drop", shift_h_en, 0);
      check("shift_h addr hold", shift_h_addr, 5'b10011);

      // NUM_SHIFT 5 with the next command already waiting
      cmd_valid = 1'b1;
      cmd_op    = NUM_SHIFT;
      cmd_arg   = 16'd5;
      tick();
      cmd_op  = SHIFT_H;
      cmd_arg = 16'h0005;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("burst s_en %0d", i), shift_s_en, 1);
         check($sformatf("burst busy %0d", i), busy, 1);
         check($sformatf("burst ready %0d", i), cmd_ready, 0);
         tick();
      end
      check("burst end s_en", shift_s_en, 0);
      check("burst end ready", cmd_ready, 1);
      check("burst addr held", shift_h_addr, 5'b10011);
      tick();
      cmd_valid = 1'b0;
      check("held cmd accepted", shift_h_en, 1);
      check("held cmd addr", shift_h_addr, 5'b00101);

      // NUM_SHIFT 0 is a NOP
      issue(NUM_SHIFT, 16'd0);
      check("num0 s_en", shift_s_en, 0);
      check("num0 busy", busy, 0);

      // N=3 calculate
      issue(N_CHANGE, 16'd3);
      check("n_cfg 3", n_cfg, 3);
      issue(CALC, 16'd0);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("calc tap %0d", i), calc_tap, i);
         check($sformatf("calc start %0d", i), calc_start, (i == 0));
         check($sformatf("calc done %0d", i), calc_done, (i == 2));
         check($sformatf("calc busy %0d", i), busy, 1);
         tick();
      end
      check("calc idle busy", busy, 0);
      check("calc idle done", calc_done, 0);
      check("calc idle ready", cmd_ready, 1);

      // N=1: start and done together
      issue(N_CHANGE, 16'd1);
      issue(CALC, 16'd0);
      check("n1 start", calc_start, 1);
      check("n1 done", calc_done, 1);
      check("n1 tap", calc_tap, 0);
      tick();
      check("n1 idle", busy, 0);

      // Configuration saturation and legal K
      issue(N_CHANGE, 16'd300);
      check("n sat", n_cfg, 255);
      check("n sat err", err_illegal, 0);
      issue(K_CHANGE, 16'd5);
      check("k 5", k_cfg, 5);

      // K out of range
      issue(K_CHANGE, 16'd64);
      check("k64 unchanged", k_cfg, 5);
      check("k64 err", err_illegal, 1);
      recover("k64");

      // N = 0
      issue(N_CHANGE, 16'd20);
      check("n 20", n_cfg, 20);
      issue(N_CHANGE, 16'd0);
      check("n0 unchanged", n_cfg, 20);
      check("n0 err", err_illegal, 1);
      recover("n0");

      // Reserved opcode, then a legal SHIFT_S
      issue(RSVD, 16'd0);
      check("op7 err", err_illegal, 1);
      recover("op7");
      issue(SHIFT_S, 16'd0);
      check("post-illegal s_en", shift_s_en, 1);

      // Reset in the 3rd cycle of a 10-strobe burst
      issue(N_CHANGE, 16'd50);
      check("n 50", n_cfg, 50);
      issue(NUM_SHIFT, 16'd10);
      check("abort burst c1", shift_s_en, 1);
      tick();
      tick();
      check("abort burst c3", shift_s_en, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort s_en", shift_s_en, 0);
      check("abort busy", busy, 0);
      check("abort n_cfg", n_cfg, 8);
      strobes = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (shift_s_en) strobes++;
      end
      check("abort no strobes", strobes, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/fir_cmd_sequencer.md
Name: fir_cmd_sequencer

Overview:
- Parametrised command sequencer for the FIR digital estimator datapath.
- Accepts 3-bit estimator opcodes over a valid/ready command port and decodes them into per-cycle control strobes: H-bank shift, S shift, output calculation.
- Holds the runtime filter configuration registers (tap count N, coefficient-set index K).
- Adds multi-cycle shift bursts and a counted calculate phase; the previous single-step decoder had neither.

Parameters:
- N_W, 8, width of tap-count register n_cfg
- K_W, 6, width of coefficient-set register k_cfg
- ARG_W, 16, width of command argument
- N_RST, 8, reset value of n_cfg (must be 1..2^N_W-1)
- K_RST, 0, reset value of k_cfg

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command this cycle
- cmd_op  in  3  opcode: 000 SHIFT_H, 001 SHIFT_S, 010 CALCULATE_O, 011 NOP, 100 NUM_SHIFT, 101 N_CHANGE, 110 K_CHANGE, 111 reserved
- cmd_arg  in  ARG_W  argument: H address, burst length, or new N/K
- shift_h_en  out  1  one-cycle H-bank shift strobe
- shift_h_addr  out  5  H address; [4:3] bank, [2:0] lane
- shift_s_en  out  1  S shift strobe
- calc_start  out  1  one-cycle pulse on the first calculate cycle
- calc_tap  out  N_W  current tap index during calculate
- calc_done  out  1  one-cycle pulse on the last calculate cycle
- busy  out  1  state != IDLE
- n_cfg  out  N_W  current tap count
- k_cfg  out  K_W  current coefficient set
- err_illegal  out  1  illegal command flag (semantics under Optional Feature)

Behaviour:
- Command accepted on a cycle where cmd_valid && cmd_ready. cmd_ready = (state == IDLE) && !trap. Upstream holds cmd_op/cmd_arg stable while ready is low.
- States: IDLE, SHIFT_BURST, CALCULATE. Reset enters IDLE.
- Reset values: all strobes 0, shift_h_addr 0, calc_tap 0, busy 0, err_illegal 0, n_cfg N_RST, k_cfg K_RST, internal burst counter 0.
- A reset mid-burst or mid-calculate aborts immediately. No calc_done is issued.
- Every output is registered. Strobes assert in the cycle after acceptance (latency 1).
- SHIFT_H:
  - shift_h_en = 1 for one cycle.
  - shift_h_addr = cmd_arg[4:0], held until the next SHIFT_H.
  - Stays in IDLE.
- SHIFT_S: shift_s_en = 1 for one cycle. Stays in IDLE.
- NUM_SHIFT with arg L:
  - L == 0 behaves as NOP.
  - Otherwise go to SHIFT_BURST and assert shift_s_en on exactly L consecutive cycles, starting the cycle after acceptance.
  - Return to IDLE after the L-th strobe. cmd_ready rises the cycle after the last strobe.
  - L is limited to ARG_W bits, with no wrap.
- CALCULATE_O:
  - Go to CALCULATE for n_cfg cycles.
  - calc_tap counts 0..n_cfg-1.
  - calc_start coincides with tap 0. calc_done coincides with tap n_cfg-1.
  - If n_cfg == 1, calc_start and calc_done assert in the same cycle.
  - Then return to IDLE.
- N_CHANGE:
  - n_cfg <= min(arg, 2^N_W-1), saturating, effective on the next cycle.
  - arg == 0 is illegal and leaves n_cfg unchanged.
- K_CHANGE:
  - k_cfg <= arg[K_W-1:0] if arg < 2^K_W.
  - Otherwise illegal and k_cfg unchanged.
- N_CHANGE and K_CHANGE are accepted only in IDLE, so configuration is never modified mid-calculate.
- NOP: no effect.
- Opcode 111 is illegal.
- A command is consumed on every handshake, including illegal ones.

Optional Feature:
- Macro: FIR_SEQ_ILLEGAL_TRAP_EN.
- Defined:
  - Any illegal command sets err_illegal sticky and sets internal trap.
  - While trapped, cmd_ready = 0 until rst.
- Undefined:
  - An illegal command acts as NOP.
  - err_illegal pulses high for one cycle (latency 1) and the sequencer keeps accepting commands.

Test Plan:
- Reset then idle -> n_cfg=8, k_cfg=0, all strobes 0, cmd_ready=1; SHIFT_H arg 0x13 -> next cycle shift_h_en=1, shift_h_addr=5'b10011.
- NUM_SHIFT arg 5 -> shift_s_en high for exactly 5 consecutive cycles, busy high for those cycles, cmd_ready low; a next command held valid is accepted the cycle after the 5th strobe. NUM_SHIFT arg 0 -> no strobe.
- N_CHANGE arg 3, then CALCULATE_O -> calc_tap 0,1,2; calc_start with tap 0; calc_done with tap 2; back to IDLE. N_CHANGE arg 1 then CALCULATE_O -> start and done in the same cycle.
- N_CHANGE arg 300 (N_W=8) -> n_cfg=255. K_CHANGE arg 64 (K_W=6) -> k_cfg unchanged, err_illegal asserted. N_CHANGE arg 0 -> n_cfg unchanged, err_illegal asserted.
- Opcode 111:
  - With FIR_SEQ_ILLEGAL_TRAP_EN: err_illegal stays 1 and cmd_ready stays 0 until rst.
  - Without it: one-cycle err_illegal pulse, and a following SHIFT_S still produces shift_s_en.
- Assert rst in the 3rd cycle of a NUM_SHIFT 10 burst -> next cycle shift_s_en=0, state IDLE, n_cfg=N_RST, no further strobes.
